qmem_rr_arbiter: RTL and testbench

Parametrised N-master to single-slave QMEM arbiter; successor to the fixed two-master slave arbiters in the QMEM interconnect.
- Adds a selectable round-robin or fixed-priority policy.
- Grant is registered and locked for the whole transfer.
- Optional slave-timeout watchdog returns err to the stalled master.
- Sits in front of each shared slave (ROM, RAM, DRAM) in the qmem bus.

---
 rtl/qmem_rr_arbiter.sv | 167 ++++++++++++++++
 tb/tb_qmem_rr_arbiter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/qmem_rr_arbiter.sv
// qmem_rr_arbiter: N-master to single-slave QMEM arbiter.
// Registered one-hot grant, locked for the whole transfer, with a selectable
// round-robin or fixed-priority policy and an optional slave-timeout watchdog.

module qmem_rr_arbiter #(
    parameter int unsigned MN  = 2,
    parameter int unsigned QAW = 22,
    parameter int unsigned QDW = 32,
    parameter int unsigned QSW = QDW / 8,
    parameter int unsigned RR  = 1,
    parameter int unsigned TMO = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [MN-1:0]     qm_cs,
    input  logic [MN-1:0]     qm_we,
    input  logic [MN*QSW-1:0] qm_sel,
    input  logic [MN*QAW-1:0] qm_adr,
    input  logic [MN*QDW-1:0] qm_dat_w,
    output logic [MN*QDW-1:0] qm_dat_r,
    output logic [MN-1:0]     qm_ack,
    output logic [MN-1:0]     qm_err,
    output logic              qs_cs,
    output logic              qs_we,
    output logic [QSW-1:0]    qs_sel,
    output logic [QAW-1:0]    qs_adr,
    output logic [QDW-1:0]    qs_dat_w,
    input  logic [QDW-1:0]    qs_dat_r,
    input  logic              qs_ack,
    input  logic              qs_err,
    output logic [MN-1:0]     ms,
    output logic              tmo_flag
);

    localparam int unsigned IW = (MN > 1) ? $clog2(MN) : 1;

    localparam logic [0:0] StIdle  = 1'b0;
    localparam logic [0:0] StGrant = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [MN-1:0] ms_q, ms_d;
    logic [IW-1:0] gnt_q, gnt_d;
    logic [IW-1:0] last_q, last_d;
    logic          tmo_flag_q, tmo_flag_d;

    logic          hi_found, lo_found, win_found;
    logic [IW-1:0] hi_idx, lo_idx, win_idx;
    logic          gnt_cs;
    logic          tmo_fire;

    // Winner search: in round-robin mode requesters above the last grant come
    // first (lowest such index), otherwise wrap to the lowest requester overall.
    always_comb begin
        hi_found = 1'b0;
        hi_idx   = '0;
        lo_found = 1'b0;
        lo_idx   = '0;
        for (int i = MN - 1; i >= 0; i--) begin
            if (qm_cs[i]) begin
                if ((RR != 0) && (i > int'(last_q))) begin
                    hi_found = 1'b1;
                    hi_idx   = IW'(i);
                end else begin
                    lo_found = 1'b1;
                    lo_idx   = IW'(i);
                end
            end
        end
    end

    assign win_found = hi_found | lo_found;
    assign win_idx   = hi_found ? hi_idx : lo_idx;

    // Slave-side mux and master-side response routing for the granted master.
    always_comb begin
        qs_cs    = 1'b0;
        qs_we    = 1'b0;
        qs_sel   = '0;
        qs_adr   = '0;
        qs_dat_w = '0;
        qm_ack   = '0;
        qm_err   = '0;
        gnt_cs   = 1'b0;
        if (state_q == StGrant) begin
            for (int i = 0; i < MN; i++) begin
                if (gnt_q == IW'(i)) begin
                    gnt_cs    = qm_cs[i];
                    qs_cs     = qm_cs[i] & ~tmo_fire;
                    qs_we     = qm_we[i];
                    qs_sel    = qm_sel[i*QSW +: QSW];
                    qs_adr    = qm_adr[i*QAW +: QAW];
                    qs_dat_w  = qm_dat_w[i*QDW +: QDW];
                    qm_ack[i] = qs_ack;
                    qm_err[i] = qs_err | tmo_fire;
                end
            end
        end
    end

    // Read data is broadcast; each master qualifies it with its own ack.
    assign qm_dat_r = {MN{qs_dat_r}};

    // Watchdog: counts grant cycles without a slave response.
    if (TMO > 0) begin : g_tmo
        localparam int unsigned CW = $clog2(TMO + 1);
        logic [CW-1:0] cnt_q;

        // Counter clears while idle so it starts at zero on every new grant.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                cnt_q <= '0;
            end else if (state_q == StIdle) begin
                cnt_q <= '0;
            end else if (!qs_ack && !qs_err) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end

        // A slave response in the expiry cycle wins over the timeout.
        assign tmo_fire = (state_q == StGrant) && (cnt_q == CW'(TMO - 1)) && !qs_ack && !qs_err;
    end else begin : g_no_tmo
        assign tmo_fire = 1'b0;
    end

    // Next-state logic: arbitrate in idle, release the grant on response/abort/timeout.
    always_comb begin
        state_d    = state_q;
        ms_d       = ms_q;
        gnt_d      = gnt_q;
        last_d     = last_q;
        tmo_flag_d = tmo_flag_q | tmo_fire;
        if (state_q == StIdle) begin
            if (win_found) begin
                state_d = StGrant;
                gnt_d   = win_idx;
                last_d  = win_idx;
                ms_d    = MN'(1) << win_idx;
            end
        end else begin
            if (qs_ack || qs_err || tmo_fire || !gnt_cs) begin
                state_d = StIdle;
                ms_d    = '0;
            end
        end
    end

    // State registers; last grant resets to MN-1 so master 0 wins first.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            ms_q       <= '0;
            gnt_q      <= '0;
            last_q     <= IW'(MN - 1);
            tmo_flag_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ms_q       <= ms_d;
            gnt_q      <= gnt_d;
            last_q     <= last_d;
            tmo_flag_q <= tmo_flag_d;
        end
    end

    assign ms       = ms_q;
    assign tmo_flag = tmo_flag_q;

endmodule

// File: tb/tb_qmem_rr_arbiter.sv
// Randomized bench for qmem_rr_arbiter: a round-robin/watchdog instance and a
// fixed-priority instance share master stimulus; each has its own slave and a
// transaction-level reference model.

module tb_qmem_rr_arbiter;

    localparam int MN  = 4;
    localparam int QAW = 22;
    localparam int QDW = 32;
    localparam int QSW = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [MN-1:0]     qm_cs, qm_we;
    logic [MN*QSW-1:0] qm_sel;
    logic [MN*QAW-1:0] qm_adr;
    logic [MN*QDW-1:0] qm_dat_w;

    logic [MN*QDW-1:0] o_dat_r [2];
    logic [MN-1:0]     o_ack   [2];
    logic [MN-1:0]     o_err   [2];
    logic [MN-1:0]     o_ms    [2];
    logic              o_cs    [2];
    logic              o_we    [2];
    logic [QSW-1:0]    o_sel   [2];
    logic [QAW-1:0]    o_adr   [2];
    logic [QDW-1:0]    o_dw    [2];
    logic              o_tmo   [2];
    logic [QDW-1:0]    s_dr    [2];
    logic              s_ack   [2];
    logic              s_err   [2];

    qmem_rr_arbiter #(.MN(MN), .QAW(QAW), .QDW(QDW), .QSW(QSW), .RR(1), .TMO(8)) u_rr (
        .clk(clk), .rst(rst), .qm_cs(qm_cs), .qm_we(qm_we), .qm_sel(qm_sel), .qm_adr(qm_adr),
        .qm_dat_w(qm_dat_w), .qm_dat_r(o_dat_r[0]), .qm_ack(o_ack[0]), .qm_err(o_err[0]),
        .qs_cs(o_cs[0]), .qs_we(o_we[0]), .qs_sel(o_sel[0]), .qs_adr(o_adr[0]),
        .qs_dat_w(o_dw[0]), .qs_dat_r(s_dr[0]), .qs_ack(s_ack[0]), .qs_err(s_err[0]),
        .ms(o_ms[0]), .tmo_flag(o_tmo[0])
    );

    qmem_rr_arbiter #(.MN(MN), .QAW(QAW), .QDW(QDW), .QSW(QSW), .RR(0), .TMO(0)) u_fp (
        .clk(clk), .rst(rst), .qm_cs(qm_cs), .qm_we(qm_we), .qm_sel(qm_sel), .qm_adr(qm_adr),
        .qm_dat_w(qm_dat_w), .qm_dat_r(o_dat_r[1]), .qm_ack(o_ack[1]), .qm_err(o_err[1]),
        .qs_cs(o_cs[1]), .qs_we(o_we[1]), .qs_sel(o_sel[1]), .qs_adr(o_adr[1]),
        .qs_dat_w(o_dw[1]), .qs_dat_r(s_dr[1]), .qs_ack(s_ack[1]), .qs_err(s_err[1]),
        .ms(o_ms[1]), .tmo_flag(o_tmo[1])
    );

    // Reference model: owner of the slave (-1 = free), last winner, cycles spent
    // in the current grant, sticky timeout flag.
    int rr_p  [2] = '{1, 0};
    int tmo_p [2] = '{8, 0};
    int own   [2];
    int last  [2];
    int cnt   [2];
    bit flag  [2];
    int ack_pct [2];
    int pcts [4] = '{0, 15, 50, 90};

    int n_pass   = 0;
    int n_checks = 0;
    int cyc      = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            own[d]  = -1;
            last[d] = MN - 1;
            cnt[d]  = 0;
            flag[d] = 1'b0;
        end
    endtask

    function automatic int pick(input int d);
        if (rr_p[d] != 0) begin
            for (int k = 1; k <= MN; k++)
                if (qm_cs[(last[d] + k) % MN]) return (last[d] + k) % MN;
        end else begin
            for (int i = 0; i < MN; i++) if (qm_cs[i]) return i;
        end
        return -1;
    endfunction

    // Compare one DUT against the model for the current cycle, then advance the model.
    task automatic eval_dut(input int d);
        string nm;
        logic [MN-1:0] e_ack, e_err, e_ms;
        logic e_cs;
        bit fire;
        int g, ng;
        nm = (d == 0) ? "rr" : "fp";
        e_ack = '0; e_err = '0; e_ms = '0; e_cs = 1'b0; fire = 1'b0;
        g = own[d];
        if (g >= 0) begin
            fire = (tmo_p[d] > 0) && (cnt[d] == tmo_p[d] - 1) && !s_ack[d] && !s_err[d];
            e_ms[g]  = 1'b1;
            e_cs     = qm_cs[g] && !fire;
            e_ack[g] = s_ack[d];
            e_err[g] = s_err[d] || fire;
            check({nm, ".qs_we"}, o_we[d], qm_we[g]);
            check({nm, ".qs_sel"}, o_sel[d], qm_sel[g*QSW +: QSW]);
            check({nm, ".qs_adr"}, o_adr[d], qm_adr[g*QAW +: QAW]);
            check({nm, ".qs_dat_w"}, o_dw[d], qm_dat_w[g*QDW +: QDW]);
        end
        check({nm, ".ms"}, o_ms[d], e_ms);
        check({nm, ".qs_cs"}, o_cs[d], e_cs);
        check({nm, ".qm_ack"}, o_ack[d], e_ack);
        check({nm, ".qm_err"}, o_err[d], e_err);
        check({nm, ".tmo_flag"}, o_tmo[d], flag[d]);
        check({nm, ".qm_dat_r"}, o_dat_r[d], {MN{s_dr[d]}});
        if (g < 0) begin
            ng = pick(d);
            if (ng >= 0) begin
                own[d]  = ng;
                last[d] = ng;
                cnt[d]  = 0;
            end
        end else if (s_ack[d] || s_err[d] || fire || !qm_cs[g]) begin
            own[d] = -1;
            if (fire) flag[d] = 1'b1;
        end else begin
            cnt[d]++;
        end
    endtask

    // One clock: new random stimulus shortly after the edge, then compare.
    task automatic step(input bit all_req);
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) ack_pct[d] = pcts[((cyc / 64) + 2 * d) % 4];
        for (int i = 0; i < MN; i++) begin
            if (all_req) qm_cs[i] = 1'b1;
            else if (!qm_cs[i]) qm_cs[i] = ($urandom_range(2) == 0);
            else if ($urandom_range(15) == 0) qm_cs[i] = 1'b0;
            qm_we[i] = 1'($urandom);
            qm_sel[i*QSW +: QSW] = QSW'($urandom);
            qm_adr[i*QAW +: QAW] = QAW'($urandom);
            qm_dat_w[i*QDW +: QDW] = $urandom;
        end
        for (int d = 0; d < 2; d++) begin
            s_ack[d] = ($urandom_range(99) < ack_pct[d]);
            s_err[d] = ($urandom_range(99) < 3);
            s_dr[d]  = $urandom;
        end
        #1;
        eval_dut(0);
        eval_dut(1);
        cyc++;
    endtask

    initial begin
        rst = 1'b0;
        qm_cs = '0; qm_we = '0; qm_sel = '0; qm_adr = '0; qm_dat_w = '0;
        for (int d = 0; d < 2; d++) begin
            s_ack[d] = 1'b0; s_err[d] = 1'b0; s_dr[d] = '0;
        end
        model_reset();
        qm_cs = '1;
        repeat (2) @(posedge clk);
        #2;
        for (int d = 0; d < 2; d++) begin
            check("rst.ms", o_ms[d], '0);
            check("rst.qs_cs", o_cs[d], 1'b0);
            check("rst.qm_ack", o_ack[d], '0);
            check("rst.qm_err", o_err[d], '0);
            check("rst.tmo_flag", o_tmo[d], 1'b0);
        end
        rst = 1'b1;
        qm_cs = '0;
        step(1'b1);
        for (int c = 0; c < 1500; c++) step(1'b0);

        // Asynchronous reset while the round-robin instance holds a grant.
        for (int c = 0; c < 300 && own[0] < 0; c++) step(1'b0);
        @(posedge clk);
        #1;
        check("pre_rst.grant_held", 32'(own[0] >= 0), 32'd1);
        if (own[0] >= 0) check("pre_rst.ms", o_ms[0], MN'(1) << own[0]);
        rst = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            check("async_rst.ms", o_ms[d], '0);
            check("async_rst.qs_cs", o_cs[d], 1'b0);
            check("async_rst.tmo_flag", o_tmo[d], 1'b0);
        end
        model_reset();
        #1;
        rst = 1'b1;
        qm_cs = '0;
        // All masters request after reset release: master 0 must win in both.
        step(1'b1);
        for (int c = 0; c < 1500; c++) step(1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
